// File: rtl/ad9643_test_mode_ctrl_if.sv
// Register-access bus between a host register interface and the AD9643 test-mode controller.
// The master drives the write/read strobes; the slave returns ready, error and read data.
interface ad9643_test_mode_ctrl_if;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       wr_err;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  wr_ready, wr_err, rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output wr_ready, wr_err, rd_data
  );
endinterface

// File: rtl/ad9643_test_mode_ctrl.sv
// AD9643 test-pattern register controller: shadow register file plus a commit FSM that
// holds the pattern generators in reset for a guard interval before applying a new setup.

module ad9643_tm_regfile (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_stb,
  input  logic [7:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [7:0]        rd_addr,
  output logic [7:0]        rd_data,
  output logic              xfer_req,
  output logic [3:0]        sh_mode,
  output logic              sh_pn_long,
  output logic              sh_pn_short,
  output logic              sh_mode_ctl,
  output logic [3:0][15:0]  sh_pattern
);

  localparam logic [7:0] ADDR_TEST_MODE = 8'h0D;
  localparam logic [7:0] ADDR_PAT1_LSB  = 8'h19;
  localparam logic [7:0] ADDR_PAT1_MSB  = 8'h1A;
  localparam logic [7:0] ADDR_PAT2_LSB  = 8'h1B;
  localparam logic [7:0] ADDR_PAT2_MSB  = 8'h1C;
  localparam logic [7:0] ADDR_PAT3_LSB  = 8'h1D;
  localparam logic [7:0] ADDR_PAT3_MSB  = 8'h1E;
  localparam logic [7:0] ADDR_PAT4_LSB  = 8'h1F;
  localparam logic [7:0] ADDR_PAT4_MSB  = 8'h20;
  localparam logic [7:0] ADDR_TRANSFER  = 8'hFF;

  logic [7:0]       test_mode_q;
  logic [3:0][15:0] pattern_q;
  logic [7:0]       rd_mux;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      test_mode_q <= 8'h00;
      pattern_q   <= '0;
    end else if (wr_stb) begin
      case (wr_addr)
        ADDR_TEST_MODE: test_mode_q        <= wr_data;
        ADDR_PAT1_LSB:  pattern_q[0][7:0]  <= wr_data;
        ADDR_PAT1_MSB:  pattern_q[0][15:8] <= wr_data;
        ADDR_PAT2_LSB:  pattern_q[1][7:0]  <= wr_data;
        ADDR_PAT2_MSB:  pattern_q[1][15:8] <= wr_data;
        ADDR_PAT3_LSB:  pattern_q[2][7:0]  <= wr_data;
        ADDR_PAT3_MSB:  pattern_q[2][15:8] <= wr_data;
        ADDR_PAT4_LSB:  pattern_q[3][7:0]  <= wr_data;
        ADDR_PAT4_MSB:  pattern_q[3][15:8] <= wr_data;
        default: ;
      endcase
    end
  end

  // Transfer register has no storage: it only produces a one-shot commit request.
  assign xfer_req = wr_stb && (wr_addr == ADDR_TRANSFER) && wr_data[0];

  always_comb begin
    rd_mux = 8'h00;
    case (rd_addr)
      ADDR_TEST_MODE: rd_mux = test_mode_q;
      ADDR_PAT1_LSB:  rd_mux = pattern_q[0][7:0];
      ADDR_PAT1_MSB:  rd_mux = pattern_q[0][15:8];
      ADDR_PAT2_LSB:  rd_mux = pattern_q[1][7:0];
      ADDR_PAT2_MSB:  rd_mux = pattern_q[1][15:8];
      ADDR_PAT3_LSB:  rd_mux = pattern_q[2][7:0];
      ADDR_PAT3_MSB:  rd_mux = pattern_q[2][15:8];
      ADDR_PAT4_LSB:  rd_mux = pattern_q[3][7:0];
      ADDR_PAT4_MSB:  rd_mux = pattern_q[3][15:8];
      default:        rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 8'h00;
    end else if (rd_en) begin
      rd_data <= rd_mux;
    end
  end

  assign sh_mode     = test_mode_q[3:0];
  assign sh_pn_long  = test_mode_q[4];
  assign sh_pn_short = test_mode_q[5];
  assign sh_mode_ctl = test_mode_q[7];
  assign sh_pattern  = pattern_q;

endmodule

// state | meaning
// IDLE  | accepting register writes; active configuration stable
// GUARD | commit in progress; select_mode held at 0, PN generators held in reset
module ad9643_test_mode_ctrl #(
  parameter int GUARD_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  ad9643_test_mode_ctrl_if.slave    bus,
  output logic [3:0]                select_mode,
  output logic                      mode_control,
  output logic [15:0]               user_pattern_1,
  output logic [15:0]               user_pattern_2,
  output logic [15:0]               user_pattern_3,
  output logic [15:0]               user_pattern_4,
  output logic                      pn_long_reset,
  output logic                      pn_short_reset,
  output logic                      busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GUARD = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(GUARD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             wr_ready_q;
  logic             wr_err_q;
  logic             wr_accept;
  logic             xfer_req;
  logic             commit;
  logic             guard_done;
  logic [3:0]       sh_mode;
  logic             sh_pn_long;
  logic             sh_pn_short;
  logic             sh_mode_ctl;
  logic [3:0][15:0] sh_pattern;
  logic [3:0]       cmt_mode_q;
  logic             cmt_pn_long_q;
  logic             cmt_pn_short_q;

  assign wr_accept = bus.wr_en && wr_ready_q;

  ad9643_tm_regfile u_regfile (
    .clk         (clk),
    .reset       (reset),
    .wr_stb      (wr_accept),
    .wr_addr     (bus.wr_addr),
    .wr_data     (bus.wr_data),
    .rd_en       (bus.rd_en),
    .rd_addr     (bus.rd_addr),
    .rd_data     (bus.rd_data),
    .xfer_req    (xfer_req),
    .sh_mode     (sh_mode),
    .sh_pn_long  (sh_pn_long),
    .sh_pn_short (sh_pn_short),
    .sh_mode_ctl (sh_mode_ctl),
    .sh_pattern  (sh_pattern)
  );

  assign commit     = xfer_req && (state_q == ST_IDLE);
  assign guard_done = (state_q == ST_GUARD) && (cnt_q == 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          state_d = ST_GUARD;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_GUARD: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Handshake flags are registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ready_q <= 1'b0;
      busy       <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_ready_q <= (state_d == ST_IDLE);
      busy       <= (state_d == ST_GUARD);
      wr_err_q   <= bus.wr_en && !wr_ready_q;
    end
  end

  assign bus.wr_ready = wr_ready_q;
  assign bus.wr_err   = wr_err_q;

  // Test-mode bits are snapshotted at commit and only released to the outputs at guard exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      select_mode    <= 4'b0000;
      mode_control   <= 1'b0;
      user_pattern_1 <= 16'h0000;
      user_pattern_2 <= 16'h0000;
      user_pattern_3 <= 16'h0000;
      user_pattern_4 <= 16'h0000;
      pn_long_reset  <= 1'b0;
      pn_short_reset <= 1'b0;
      cmt_mode_q     <= 4'b0000;
      cmt_pn_long_q  <= 1'b0;
      cmt_pn_short_q <= 1'b0;
    end else if (commit) begin
      user_pattern_1 <= sh_pattern[0];
      user_pattern_2 <= sh_pattern[1];
      user_pattern_3 <= sh_pattern[2];
      user_pattern_4 <= sh_pattern[3];
      mode_control   <= sh_mode_ctl;
      select_mode    <= 4'b0000;
      pn_long_reset  <= 1'b1;
      pn_short_reset <= 1'b1;
      cmt_mode_q     <= sh_mode;
      cmt_pn_long_q  <= sh_pn_long;
      cmt_pn_short_q <= sh_pn_short;
    end else if (guard_done) begin
      select_mode    <= cmt_mode_q;
      pn_long_reset  <= cmt_pn_long_q;
      pn_short_reset <= cmt_pn_short_q;
    end
  end

endmodule

// File: tb/tb_ad9643_test_mode_ctrl.sv
// Directed bench for ad9643_test_mode_ctrl: register read/write vectors plus commit,
// guard-interval, mid-guard reset and single-cycle-guard sequences.
module tb_ad9643_test_mode_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ad9643_test_mode_ctrl_if bus ();
  ad9643_test_mode_ctrl_if bus1 ();

  logic [3:0]  select_mode, sm1;
  logic        mode_control, mc1;
  logic [15:0] up1, up2, up3, up4;
  logic [15:0] up1_b, up2_b, up3_b, up4_b;
  logic        pnl, pns, busy;
  logic        pnl1, pns1, busy1;

  ad9643_test_mode_ctrl #(.GUARD_CYCLES(4)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .select_mode    (select_mode),
    .mode_control   (mode_control),
    .user_pattern_1 (up1),
    .user_pattern_2 (up2),
    .user_pattern_3 (up3),
    .user_pattern_4 (up4),
    .pn_long_reset  (pnl),
    .pn_short_reset (pns),
    .busy           (busy)
  );

  ad9643_test_mode_ctrl #(.GUARD_CYCLES(1)) u_dut1 (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus1),
    .select_mode    (sm1),
    .mode_control   (mc1),
    .user_pattern_1 (up1_b),
    .user_pattern_2 (up2_b),
    .user_pattern_3 (up3_b),
    .user_pattern_4 (up4_b),
    .pn_long_reset  (pnl1),
    .pn_short_reset (pns1),
    .busy           (busy1)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       we;
    logic [7:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [7:0] ra;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [7:0] wa, input logic [7:0] wd,
                       input logic re, input logic [7:0] ra);
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.rd_addr = ra;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit_step();
    drive(1'b1, 8'hFF, 8'h01, 1'b0, 8'h00);
    step();
    idle();
  endtask

  task automatic write_step(input logic [7:0] wa, input logic [7:0] wd);
    drive(1'b1, wa, wd, 1'b0, 8'h00);
    step();
    idle();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'h19, 8'h34, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 8'h1A, 8'h12, 1'b1, 8'h19, 8'h34};
    vecs[2]  = '{1'b1, 8'h1F, 8'hAB, 1'b1, 8'h1A, 8'h12};
    vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h1F, 8'hAB};
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h00};
    vecs[5]  = '{1'b1, 8'h1B, 8'h5A, 1'b1, 8'h1F, 8'hAB};
    vecs[6]  = '{1'b1, 8'h55, 8'h77, 1'b1, 8'h55, 8'h00};
    vecs[7]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h1B, 8'h5A};
    vecs[8]  = '{1'b1, 8'h0D, 8'h08, 1'b1, 8'h0D, 8'h00};
    vecs[9]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h0D, 8'h08};
    vecs[10] = '{1'b1, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h08};
    vecs[11] = '{1'b1, 8'h20, 8'hCD, 1'b1, 8'h20, 8'h00};
    vecs[12] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h20, 8'hCD};
    vecs[13] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h55, 8'h00};

    reset = 1'b1;
    idle();
    bus1.wr_en = 1'b0; bus1.wr_addr = 8'h00; bus1.wr_data = 8'h00;
    bus1.rd_en = 1'b0; bus1.rd_addr = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_select_mode", select_mode, 4'h0);
    chk("rst_wr_ready", bus.wr_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_data", bus.rd_data, 8'h00);
    chk("rst_pn", {pnl, pns}, 2'b00);
    reset = 1'b0;
    #1;
    chk("rel_wr_ready_pre_edge", bus.wr_ready, 1'b0);
    step();
    chk("rel_wr_ready_first_edge", bus.wr_ready, 1'b1);

    // Register-file vectors, all in IDLE.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
      step();
      chk($sformatf("vec%0d_rd_data", i), bus.rd_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d_wr_err", i), bus.wr_err, 1'b0);
      chk($sformatf("vec%0d_busy", i), busy, 1'b0);
      chk($sformatf("vec%0d_select_mode", i), select_mode, 4'h0);
    end
    idle();

    // Commit with 0x0D=0x08, patterns 1=0x1234, 2=0x005A, 4=0xCDAB.
    commit_step();
    chk("T_up1", up1, 16'h1234);
    chk("T_up2", up2, 16'h005A);
    chk("T_up3", up3, 16'h0000);
    chk("T_up4", up4, 16'hCDAB);
    chk("T_select", select_mode, 4'h0);
    chk("T_busy", busy, 1'b1);
    chk("T_wr_ready", bus.wr_ready, 1'b0);
    chk("T_pn", {pnl, pns}, 2'b11);
    chk("T_mode_control", mode_control, 1'b0);
    drive(1'b1, 8'h0D, 8'h00, 1'b0, 8'h00);
    step();
    chk("T1_wr_err", bus.wr_err, 1'b1);
    chk("T1_busy", busy, 1'b1);
    chk("T1_select", select_mode, 4'h0);
    drive(1'b1, 8'hFF, 8'h01, 1'b0, 8'h00);
    step();
    chk("T2_wr_err_xfer", bus.wr_err, 1'b1);
    chk("T2_select", select_mode, 4'h0);
    idle();
    step();
    chk("T3_wr_err_clear", bus.wr_err, 1'b0);
    chk("T3_busy", busy, 1'b1);
    chk("T3_select", select_mode, 4'h0);
    step();
    chk("T4_busy", busy, 1'b0);
    chk("T4_wr_ready", bus.wr_ready, 1'b1);
    chk("T4_select", select_mode, 4'h8);
    chk("T4_pn", {pnl, pns}, 2'b00);
    step();
    chk("T5_busy_stays_low", busy, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h0D);
    step();
    idle();
    chk("dropped_write_rd_0D", bus.rd_data, 8'h08);
    chk("dropped_write_select", select_mode, 4'h8);

    // Single-pass mode commit, then recommit back to continuous mode.
    write_step(8'h0D, 8'h88);
    commit_step();
    chk("mc_T_mode_control", mode_control, 1'b1);
    chk("mc_T_select", select_mode, 4'h0);
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("mc_T%0d_select", k), select_mode, 4'h0);
    end
    step();
    chk("mc_T4_select", select_mode, 4'h8);
    chk("mc_T4_busy", busy, 1'b0);
    write_step(8'h0D, 8'h08);
    commit_step();
    chk("rc_T_mode_control", mode_control, 1'b0);
    chk("rc_T_select", select_mode, 4'h0);
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("rc_T%0d_select", k), select_mode, 4'h0);
      chk($sformatf("rc_T%0d_busy", k), busy, 1'b1);
    end
    step();
    chk("rc_T4_select", select_mode, 4'h8);

    // Reset during GUARD: outputs clear asynchronously and the commit is lost.
    commit_step();
    step();
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_select", select_mode, 4'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_wr_ready", bus.wr_ready, 1'b0);
    chk("mid_rst_up1", up1, 16'h0000);
    chk("mid_rst_up4", up4, 16'h0000);
    chk("mid_rst_pn", {pnl, pns}, 2'b00);
    chk("mid_rst_rd_data", bus.rd_data, 8'h00);
    chk("mid_rst_mode_control", mode_control, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    chk("post_rst_wr_ready", bus.wr_ready, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("post_rst%0d_select", k), select_mode, 4'h0);
      chk($sformatf("post_rst%0d_busy", k), busy, 1'b0);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h0D);
    step();
    idle();
    chk("post_rst_rd_0D", bus.rd_data, 8'h00);

    // PN resets forced high through GUARD, then the committed levels.
    write_step(8'h0D, 8'h36);
    commit_step();
    chk("pn_T_pn", {pnl, pns}, 2'b11);
    chk("pn_T_select", select_mode, 4'h0);
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("pn_T%0d_pn", k), {pnl, pns}, 2'b11);
    end
    step();
    chk("pn_T4_long", pnl, 1'b1);
    chk("pn_T4_short", pns, 1'b1);
    chk("pn_T4_select", select_mode, 4'h6);
    chk("pn_T4_busy", busy, 1'b0);

    // GUARD_CYCLES=1 instance: select_mode is 0 for exactly one cycle.
    bus1.wr_en = 1'b1; bus1.wr_addr = 8'h0D; bus1.wr_data = 8'h08;
    step();
    bus1.wr_addr = 8'hFF; bus1.wr_data = 8'h01;
    step();
    bus1.wr_en = 1'b0;
    chk("g1_T_select", sm1, 4'h0);
    chk("g1_T_busy", busy1, 1'b1);
    chk("g1_T_pn", {pnl1, pns1}, 2'b11);
    step();
    chk("g1_T1_select", sm1, 4'h8);
    chk("g1_T1_busy", busy1, 1'b0);
    chk("g1_T1_wr_ready", bus1.wr_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ad9643_test_mode_ctrl.md
# ad9643_test_mode_ctrl

Register-side controller for the AD9643 output test-pattern path. It receives register-map writes and reads, holds shadow copies of the test-mode register (0x0D) and the four user-pattern registers (0x19–0x20), and commits them to the user-test-pattern FSM and PN generators on a transfer command (0xFF bit 0). Every commit forces the pattern FSM into its reset state for a guard interval, so a new configuration always starts from pattern 1.

## Interface
- GUARD_CYCLES, 4: number of `clk` cycles `select_mode` is forced to 4'b0000 on each commit; legal range 1–255.

Ports:
- clk  in  1  clock; all outputs change on its rising edge only.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe; accepted only when `wr_ready`=1.
- wr_addr  in  8  write register address.
- wr_data  in  8  write data.
- wr_ready  out  1  controller can accept a write.
- wr_err  out  1  one-cycle pulse: `wr_en` was asserted while `wr_ready`=0, and the write was dropped.
- rd_en  in  1  read strobe; always accepted.
- rd_addr  in  8  read register address.
- rd_data  out  8  read data, registered.
- select_mode  out  4  active output test mode to the pattern generators.
- mode_control  out  1  user-pattern mode: 1 = single pass, 0 = continuous repeat.
- user_pattern_1 … user_pattern_4  out  16 each  active user patterns.
- pn_long_reset  out  1  active level of register 0x0D bit 4.
- pn_short_reset  out  1  active level of register 0x0D bit 5.
- busy  out  1  a commit is in progress (GUARD state).

## Operation
- Register map, shadow side:
  - 0x0D: [3:0] test mode, [4] PN-long reset, [5] PN-short reset, [7] user mode control, [6] stored but unused.
  - 0x19/0x1A: pattern 1 LSB/MSB.
  - 0x1B/0x1C: pattern 2 LSB/MSB.
  - 0x1D/0x1E: pattern 3 LSB/MSB.
  - 0x1F/0x20: pattern 4 LSB/MSB.
  - 0xFF: transfer. Writing bit 0 = 1 triggers a commit; the register is self-clearing and always reads 0x00.
- An accepted write to a mapped address updates its shadow byte. Writes to unmapped addresses are ignored without error. Writing 0xFF with bit 0 = 0 has no effect.
- A read returns the shadow value of the addressed register. Unmapped addresses and 0xFF read 0x00.
- State machine:
  - IDLE: `wr_ready`=1, `busy`=0. A transfer write moves to GUARD.
  - GUARD: `wr_ready`=0, `busy`=1. A down-counter runs GUARD_CYCLES cycles, then returns to IDLE.
- On the commit edge T (the transfer write is accepted):
  - Shadow patterns are copied to `user_pattern_1..4`.
  - Shadow bit 7 is copied to `mode_control`.
  - `select_mode` is set to 4'b0000, and both PN resets are set to 1.
  - The counter is loaded with GUARD_CYCLES-1.
- On the exit edge T+GUARD_CYCLES:
  - `select_mode` takes the committed shadow[3:0].
  - `pn_long_reset` / `pn_short_reset` take the committed bits 4 and 5.
  - State returns to IDLE.
- Committed test-mode bits are latched at T. Shadow writes cannot occur during GUARD, because `wr_ready`=0.
- The guard interval deasserts the pattern FSM's enable (its enable decode is `select_mode`==4'b1000), restarting it at pattern 1 with index 0.
- A commit with an unchanged configuration still runs the full GUARD sequence.

## Timing
- Reset values:
  - `select_mode`=0, `mode_control`=0, all patterns 0, both PN resets 0, `busy`=0, `wr_err`=0, `rd_data`=0x00, all shadow registers 0, state IDLE.
  - `wr_ready`=0 while `reset` is high and 1 on the first edge after release.
- Write at edge N: the shadow value is readable by a read issued at edge N+1.
- Read latency: one cycle. `rd_data` is valid after the edge that samples `rd_en` and holds until the next read.
- Same-edge `wr_en` and `rd_en` to the same address: `rd_data` returns the pre-write value.
- `wr_err` is high for exactly the one cycle following the dropped write. It asserts on every dropped write, including transfer writes during GUARD.
- GUARD_CYCLES=1: `select_mode` is 0 for exactly one cycle.
- Reset asserted mid-GUARD: all outputs go to their reset values immediately (asynchronously), the counter clears, and state goes to IDLE. The pending commit is lost and is not resumed after release.
- The counter never wraps: it stops at 0 and leaves GUARD.

## Test plan
- Write 0x19=0x34, 0x1A=0x12, 0x0D=0x08, 0xFF=0x01 → `user_pattern_1`=0x1234 at T; `select_mode`=0 for 4 cycles, then 4'b1000; `busy` high exactly 4 cycles.
- Read-back: write 0x1F=0xAB, read 0x1F next cycle → `rd_data`=0xAB; read 0xFF and 0x55 → 0x00.
- During GUARD, write 0x0D=0x00 with `wr_en` → `wr_err` one-cycle pulse; after the commit completes, read 0x0D returns the old value and `select_mode` stays 4'b1000.
- Commit with 0x0D=0x88 → `mode_control`=1 at T, `select_mode`=4'b1000 at T+4; recommit with 0x0D=0x08 → `mode_control`=0 and `select_mode` returns to 0 for 4 cycles.
- Assert `reset` at T+2 of a commit → all outputs 0 immediately; after release, `wr_ready`=1 and `select_mode` stays 0 with no commit resumed.
- Commit with 0x0D=0x36 → PN resets forced to 1 during GUARD, then `pn_long_reset`=1, `pn_short_reset`=1, `select_mode`=4'b0110.
